// File: rtl/countdown_display_pkg.sv
// Shared types and constants for the countdown display: converter states,
// seven-segment patterns (active-low {dp,g,f,e,d,c,b,a}) and datapath widths.
package countdown_display_pkg;

  localparam int BIN_W      = 16;
  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SHIFT_W    = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK   = 8'h80;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/countdown_display_if.sv
// Display bus: the time value and flash request in, six segment patterns out.
interface countdown_display_if;
  import countdown_display_pkg::*;

  logic [BIN_W-1:0] value;
  logic             flash;
  logic [7:0]       hex0;
  logic [7:0]       hex1;
  logic [7:0]       hex2;
  logic [7:0]       hex3;
  logic [7:0]       hex4;
  logic [7:0]       hex5;

  modport master (
    output value, flash,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  value, flash,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 18-cycle period
// (1 IDLE sample, 16 SHIFT, 1 LOAD that publishes all digits at once).
module bin2bcd_seq
  import countdown_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;

  // Add-3 correction on every BCD nibble that would overflow after the shift
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign adj[gi*4 +: 4] = (shift_q[BIN_W + gi*4 +: 4] >= 4'd5)
                          ? shift_q[BIN_W + gi*4 +: 4] + 4'd3
                          : shift_q[BIN_W + gi*4 +: 4];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {{BCD_W{1'b0}}, bin};
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {adj[BCD_W-2:0], shift_q[BIN_W-1:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = shift_q[SHIFT_W-1:BIN_W];
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/countdown_display.sv
// Seconds.centiseconds display: continuous BCD conversion of value, leading-zero
// blanking, segment encoding and optional blinking in a registered output stage.
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int BLINK_CYCLES = 50
) (
  input logic                 clk,
  input logic                 reset,
  countdown_display_if.slave  bus
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  logic             conv_start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             blank;
  logic [3:0]       dig   [NUM_DIGITS];
  logic [7:0]       seg   [NUM_DIGITS];
  logic [7:0]       hex_d [NUM_DIGITS];
  logic [7:0]       hex_q [NUM_DIGITS];

  assign conv_start = ~conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (bus.value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    assign dig[gi] = conv_bcd[gi*4 +: 4];
  end

  always_comb begin
    valid_d     = valid_q | conv_done;
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (bus.flash) begin
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
      end
    end
  end

  // Digits stay dark until the first complete conversion after reset lands
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) seg[i] = seg_encode(dig[i]);
    seg[2] = seg[2] & ~DP_MASK;
    if (dig[4] == 4'd0) seg[4] = SEG_BLANK;
    if (dig[4] == 4'd0 && dig[3] == 4'd0) seg[3] = SEG_BLANK;
    blank = ~valid_q | (bus.flash & ~phase_q);
    for (int i = 0; i < NUM_DIGITS; i++) hex_d[i] = blank ? SEG_BLANK : seg[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      valid_q     <= valid_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign bus.hex0 = hex_q[0];
  assign bus.hex1 = hex_q[1];
  assign bus.hex2 = hex_q[2];
  assign bus.hex3 = hex_q[3];
  assign bus.hex4 = hex_q[4];
  assign bus.hex5 = SEG_BLANK;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with BLINK_CYCLES=4; expected patterns
// are hand-computed as {hex5,hex4,hex3,hex2,hex1,hex0}.
module tb_countdown_display;

  localparam logic [47:0] ALL_FF  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] D12345  = 48'hFF_F9_A4_30_99_92;
  localparam logic [47:0] D5      = 48'hFF_FF_FF_40_C0_92;
  localparam logic [47:0] D65535  = 48'hFF_82_92_12_B0_92;
  localparam logic [47:0] D100    = 48'hFF_FF_FF_79_C0_C0;
  localparam logic [47:0] D200    = 48'hFF_FF_FF_24_C0_C0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  countdown_display_if bus ();

  countdown_display #(.BLINK_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    got = {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
    $display("check %0d %s got %h exp %h", checks, tag, got, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.value = 16'd0;
    bus.flash = 1'b0;

    wait_n(3);
    chk("reset_state", ALL_FF);

    // Release edge R samples 12345; digits must appear after R+18, not before
    reset = 1'b0;
    bus.value = 16'd12345;
    wait_n(18);
    chk("pre_first_load", ALL_FF);
    wait_n(1);
    chk("v12345", D12345);

    bus.value = 16'd5;
    wait_n(35);
    chk("hold_12345", D12345);
    wait_n(1);
    chk("v5", D5);

    bus.value = 16'd65535;
    wait_n(36);
    chk("v65535", D65535);

    // 100 sampled at R+108, 200 applied 3 cycles later and ignored until R+126
    bus.value = 16'd100;
    wait_n(21);
    bus.value = 16'd200;
    wait_n(14);
    chk("hold_65535", D65535);
    wait_n(1);
    chk("v100", D100);
    wait_n(9);
    chk("no_mix", D100);
    wait_n(8);
    chk("hold_100", D100);
    wait_n(1);
    chk("v200", D200);

    bus.value = 16'd100;
    wait_n(36);
    chk("v100_again", D100);

    // Blink: on for 4 cycles, off for 4, repeating from the first flash edge F
    bus.flash = 1'b1;
    wait_n(1);
    chk("blink_on_f0", D100);
    wait_n(3);
    chk("blink_on_f3", D100);
    wait_n(1);
    chk("blink_off_f4", ALL_FF);
    wait_n(3);
    chk("blink_off_f7", ALL_FF);
    wait_n(1);
    chk("blink_on_f8", D100);
    wait_n(4);
    chk("blink_off_f12", ALL_FF);
    wait_n(1);
    chk("blink_off_f13", ALL_FF);
    bus.flash = 1'b0;
    wait_n(1);
    chk("flash_drop", D100);

    // Sample of 5 at R+198 is cut short by reset at SHIFT cycle 8 (R+206)
    bus.value = 16'd5;
    wait_n(10);
    reset = 1'b1;
    wait_n(1);
    chk("mid_reset", ALL_FF);
    reset = 1'b0;
    bus.value = 16'd65535;
    wait_n(18);
    chk("post_reset_pre", ALL_FF);
    wait_n(1);
    chk("post_reset_v65535", D65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter: BLINK_CYCLES, default 50, half-period of the flash blink in clk cycles (0.5 s at 100 Hz).
REQ-002 Port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: value  input  16  time to display, unsigned centiseconds (0..65535).
REQ-005 Port: flash  input  1  level; 1 = blink the display, 0 = steady.
REQ-006 Ports: hex0..hex5  output  8 each  seven-segment patterns, active-low, bit order {dp,g,f,e,d,c,b,a}; hex0 is least significant.

Function
REQ-007 The block SHALL display value as seconds.centiseconds: hex1/hex0 = centisecond tens/units, hex2 = seconds units with dp lit, hex3 = seconds tens, hex4 = seconds hundreds.
REQ-008 hex5 SHALL always be blank (8'hFF).
REQ-009 Digit encodings SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; the hex2 pattern has bit7 cleared.
REQ-010 Leading-zero blanking: hex4 SHALL be blank when its digit is 0; hex3 SHALL be blank when its digit and hex4's digit are both 0; hex2..hex0 are never leading-blanked.
REQ-011 Binary-to-BCD conversion SHALL be iterative double-dabble with states IDLE, SHIFT, and LOAD, one shift per cycle.
REQ-012 State transitions:
  - IDLE latches value and enters SHIFT on every cycle it is not in reset.
  - SHIFT lasts exactly 16 cycles, then goes to LOAD.
  - LOAD updates all five digit registers atomically, then returns to IDLE.
REQ-013 Latency: a value sampled at edge N SHALL appear on the hex outputs after edge N+18. The conversion period is 18 cycles.
REQ-014 Changes to value during SHIFT or LOAD SHALL be ignored until the next IDLE sample. Outputs SHALL never show digits from two different samples.
REQ-015 Blink counter:
  - Counts 0..BLINK_CYCLES-1 while flash=1; phase toggles on wrap.
  - phase=on shows the digits; phase=off drives hex0..hex4 to 8'hFF.
REQ-016 On a flash 0->1 transition, the display SHALL stay on for the first BLINK_CYCLES cycles, then alternate off/on every BLINK_CYCLES cycles.
REQ-017 While flash=0, counter and phase SHALL be held at 0/on. Digits SHALL be visible from the edge after flash is sampled low, even mid-off-phase.
REQ-018 Blink gating SHALL be applied in the hex output register stage, one cycle after flash is sampled; the converter SHALL keep running while blanked.
REQ-019 Maximum value 65535 SHALL display as "655.35" without overflow; BCD width is 5 digits (20 bits).

Reset
REQ-020 While reset=1 at a posedge, the block SHALL return to IDLE, clear the shift and BCD registers and the blink counter/phase (on), and drive hex0..hex5 to 8'hFF.
REQ-021 Outputs SHALL remain 8'hFF until the first LOAD after reset releases, 18 cycles after the release edge.
REQ-022 Reset asserted mid-conversion SHALL abandon the conversion. The partial result SHALL never reach the outputs.

Structure
REQ-023 Package countdown_display_pkg SHALL hold the converter state enum, the 10 digit segment constants, SEG_BLANK (8'hFF), and DP_MASK.
REQ-024 The converter SHALL be a sub-module bin2bcd_seq with 16-bit binary in and 20-bit BCD out. Interface: start/busy/done, where done is a 1-cycle pulse in LOAD. The top level holds blanking, blink, and segment encoding.

Verification
REQ-025 Reset, then value=12345 with flash=0: hex4..hex0 = F9,A4,30,99,92 ("123.45") by cycle 18; hex5=FF.
REQ-026 value=5: hex4=FF, hex3=FF, hex2=40, hex1=C0, hex0=92 ("0.05"); value=65535 gives 82,92,12,B0,92.
REQ-027 BLINK_CYCLES=4, value=100, flash=1: hex0..hex4 on for 4 cycles, FF for 4, repeating. Dropping flash during an off phase restores "1.00" on the next cycle.
REQ-028 value=100 is sampled, then value=200 is applied 3 cycles later: outputs show "1.00" at cycle 18 and "2.00" at cycle 36, with no mixed digits in between.
REQ-029 reset pulsed at SHIFT cycle 8: all hex outputs = FF on the next cycle, and the first valid digits appear 18 cycles after reset deasserts.
